// File: rtl/vga_pkg.sv
// Shared VGA timing constants (640x480@60) and small helpers.
package vga_pkg;

  localparam int COORD_W   = 10;
  localparam int MAX_TOTAL = 1 << COORD_W;

  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;

  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;

  // Map "sync window active" to the pin level for the chosen polarity.
  function automatic logic sync_level(input logic active, input logic active_low);
    return active ^ active_low;
  endfunction

endpackage

// File: rtl/vga_axis.sv
// One raster axis: wrapping position counter plus visible and sync-window decode.
module vga_axis
  import vga_pkg::*;
#(
  parameter int TOTAL      = 800,
  parameter int VISIBLE    = 640,
  parameter int SYNC_START = 656,
  parameter int SYNC_END   = 752
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  output logic [COORD_W-1:0] cnt,
  output logic               wrap,
  output logic               at_zero,
  output logic               visible,
  output logic               sync_act
);

  // One extra bit so a window ending at exactly MAX_TOTAL still fits.
  localparam logic [COORD_W:0] LAST_L = (COORD_W+1)'(TOTAL - 1);
  localparam logic [COORD_W:0] VIS_L  = (COORD_W+1)'(VISIBLE);
  localparam logic [COORD_W:0] SS_L   = (COORD_W+1)'(SYNC_START);
  localparam logic [COORD_W:0] SE_L   = (COORD_W+1)'(SYNC_END);

  logic [COORD_W:0] cnt_ext;

  assign cnt_ext  = {1'b0, cnt};
  assign wrap     = en && (cnt_ext == LAST_L);
  assign at_zero  = (cnt == '0);
  assign visible  = (cnt_ext < VIS_L);
  assign sync_act = (cnt_ext >= SS_L) && (cnt_ext < SE_L);

  // Advance when enabled, returning to 0 after the last position.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= wrap ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/vga_timing.sv
// 640x480@60 raster timing: two chained axes and a registered output stage.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_VISIBLE       = VGA_H_VISIBLE,
  parameter int H_FRONT         = VGA_H_FRONT,
  parameter int H_SYNC          = VGA_H_SYNC,
  parameter int H_BACK          = VGA_H_BACK,
  parameter int V_VISIBLE       = VGA_V_VISIBLE,
  parameter int V_FRONT         = VGA_V_FRONT,
  parameter int V_SYNC          = VGA_V_SYNC,
  parameter int V_BACK          = VGA_V_BACK,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  output logic               hs,
  output logic               vs,
  output logic               video_on,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               line_start,
  output logic               frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_total_check
    $fatal(1, "vga_timing: H_TOTAL/V_TOTAL exceed coordinate range");
  end

  logic [COORD_W-1:0] h_cnt, v_cnt;
  logic h_wrap, h_zero, h_vis, h_sync;
  logic v_zero, v_vis, v_sync;
  // The vertical wrap has no consumer: frame_start is decoded from the counters.
  logic v_wrap_unused;

  vga_axis #(
    .TOTAL      (H_TOTAL),
    .VISIBLE    (H_VISIBLE),
    .SYNC_START (H_VISIBLE + H_FRONT),
    .SYNC_END   (H_VISIBLE + H_FRONT + H_SYNC)
  ) u_h_axis (
    .clk      (clk),
    .rst      (rst),
    .en       (1'b1),
    .cnt      (h_cnt),
    .wrap     (h_wrap),
    .at_zero  (h_zero),
    .visible  (h_vis),
    .sync_act (h_sync)
  );

  vga_axis #(
    .TOTAL      (V_TOTAL),
    .VISIBLE    (V_VISIBLE),
    .SYNC_START (V_VISIBLE + V_FRONT),
    .SYNC_END   (V_VISIBLE + V_FRONT + V_SYNC)
  ) u_v_axis (
    .clk      (clk),
    .rst      (rst),
    .en       (h_wrap),
    .cnt      (v_cnt),
    .wrap     (v_wrap_unused),
    .at_zero  (v_zero),
    .visible  (v_vis),
    .sync_act (v_sync)
  );

  // Register the decode of the current (h,v) so every output lags the counters by one cycle.
  // NOTE: async reset forces syncs inactive immediately, so no partial pulse survives a reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs          <= sync_level(1'b0, SYNC_ACTIVE_LOW);
      vs          <= sync_level(1'b0, SYNC_ACTIVE_LOW);
      video_on    <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hs          <= sync_level(h_sync, SYNC_ACTIVE_LOW);
      vs          <= sync_level(v_sync, SYNC_ACTIVE_LOW);
      video_on    <= h_vis && v_vis;
      x           <= h_cnt;
      y           <= v_cnt;
      line_start  <= h_zero;
      frame_start <= h_zero && v_zero;
    end
  end

endmodule

// File: tb/tb_vga_timing.sv
// Self-checking bench: default 640x480 instance plus two reduced-size instances
// (active-low and active-high sync) checked against a scoreboard of model packets.
module tb_vga_timing;

  // Reduced raster for frame-level checks: H 8/2/3/2 (15), V 4/2/2/1 (9).
  localparam int SH_VIS = 8, SH_FP = 2, SH_SY = 3, SH_BP = 2;
  localparam int SV_VIS = 4, SV_FP = 2, SV_SY = 2, SV_BP = 1;
  localparam int SH_TOT = SH_VIS + SH_FP + SH_SY + SH_BP;
  localparam int SV_TOT = SV_VIS + SV_FP + SV_SY + SV_BP;
  localparam int DH_TOT = 800, DV_TOT = 525;

  logic clk, rst;

  logic       d_hs, d_vs, d_von, d_ls, d_fs;
  logic [9:0] d_x, d_y;
  logic       l_hs, l_vs, l_von, l_ls, l_fs;
  logic [9:0] l_x, l_y;
  logic       h_hs, h_vs, h_von, h_ls, h_fs;
  logic [9:0] h_x, h_y;

  int n_checks = 0;
  int n_fail   = 0;

  vga_timing u_def (
    .clk(clk), .rst(rst), .hs(d_hs), .vs(d_vs), .video_on(d_von),
    .x(d_x), .y(d_y), .line_start(d_ls), .frame_start(d_fs)
  );

  vga_timing #(
    .H_VISIBLE(SH_VIS), .H_FRONT(SH_FP), .H_SYNC(SH_SY), .H_BACK(SH_BP),
    .V_VISIBLE(SV_VIS), .V_FRONT(SV_FP), .V_SYNC(SV_SY), .V_BACK(SV_BP),
    .SYNC_ACTIVE_LOW(1'b1)
  ) u_lo (
    .clk(clk), .rst(rst), .hs(l_hs), .vs(l_vs), .video_on(l_von),
    .x(l_x), .y(l_y), .line_start(l_ls), .frame_start(l_fs)
  );

  vga_timing #(
    .H_VISIBLE(SH_VIS), .H_FRONT(SH_FP), .H_SYNC(SH_SY), .H_BACK(SH_BP),
    .V_VISIBLE(SV_VIS), .V_FRONT(SV_FP), .V_SYNC(SV_SY), .V_BACK(SV_BP),
    .SYNC_ACTIVE_LOW(1'b0)
  ) u_hi (
    .clk(clk), .rst(rst), .hs(h_hs), .vs(h_vs), .video_on(h_von),
    .x(h_x), .y(h_y), .line_start(h_ls), .frame_start(h_fs)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Packet layout: {x[9:0], y[9:0], hs, vs, video_on, line_start, frame_start}.
  function automatic logic [24:0] model_pkt(input int h, input int v,
                                            input int hvis, input int hfp, input int hsy,
                                            input int vvis, input int vfp, input int vsy,
                                            input bit active_low);
    bit hs_act, vs_act;
    hs_act = (h >= hvis + hfp) && (h < hvis + hfp + hsy);
    vs_act = (v >= vvis + vfp) && (v < vvis + vfp + vsy);
    return {10'(h), 10'(v), hs_act ^ active_low, vs_act ^ active_low,
            (h < hvis) && (v < vvis), h == 0, (h == 0) && (v == 0)};
  endfunction

  // Reference raster position for each geometry.
  int mh_d = 0, mv_d = 0, mh_s = 0, mv_s = 0;
  logic [24:0] q_def[$];
  logic [24:0] q_lo[$];
  logic [24:0] q_hi[$];

  // Stimulus side: each clock edge out of reset decodes the model position, which
  // the DUT must present after that edge.
  always @(posedge clk) begin
    if (rst) begin
      mh_d <= 0; mv_d <= 0; mh_s <= 0; mv_s <= 0;
      q_def.delete(); q_lo.delete(); q_hi.delete();
    end else begin
      q_def.push_back(model_pkt(mh_d, mv_d, 640, 16, 96, 480, 10, 2, 1'b1));
      q_lo.push_back(model_pkt(mh_s, mv_s, SH_VIS, SH_FP, SH_SY, SV_VIS, SV_FP, SV_SY, 1'b1));
      q_hi.push_back(model_pkt(mh_s, mv_s, SH_VIS, SH_FP, SH_SY, SV_VIS, SV_FP, SV_SY, 1'b0));
      mh_d <= (mh_d == DH_TOT - 1) ? 0 : mh_d + 1;
      mv_d <= (mh_d == DH_TOT - 1) ? ((mv_d == DV_TOT - 1) ? 0 : mv_d + 1) : mv_d;
      mh_s <= (mh_s == SH_TOT - 1) ? 0 : mh_s + 1;
      mv_s <= (mh_s == SH_TOT - 1) ? ((mv_s == SV_TOT - 1) ? 0 : mv_s + 1) : mv_s;
    end
  end

  // Output side: compare on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst && q_def.size() > 0) begin
      check("def_pkt", 32'({d_x, d_y, d_hs, d_vs, d_von, d_ls, d_fs}), 32'(q_def.pop_front()));
      check("lo_pkt",  32'({l_x, l_y, l_hs, l_vs, l_von, l_ls, l_fs}), 32'(q_lo.pop_front()));
      check("hi_pkt",  32'({h_x, h_y, h_hs, h_vs, h_von, h_ls, h_fs}), 32'(q_hi.pop_front()));
    end
  end

  initial begin
    int hs_low, hs_min_x, hs_max_x, last_ls, last_fs;
    int vs_low_lo, vs_high_hi, hs_high_hi, von_bad;
    int prev_x, prev_y, wraps_seen;
    bit found;

    hs_low = 0; hs_min_x = 1023; hs_max_x = -1; last_ls = -1; last_fs = -1;
    vs_low_lo = 0; vs_high_hi = 0; hs_high_hi = 0; von_bad = 0;
    prev_x = -1; prev_y = -1; wraps_seen = 0;

    // Reset state.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_def", 32'({d_x, d_y, d_hs, d_vs, d_von, d_ls, d_fs}), 32'({10'd0, 10'd0, 5'b11000}));
    check("rst_hi_sync", 32'({h_hs, h_vs}), 32'(2'b00));

    // Release on a falling edge; the next rising edge is the first one.
    rst = 1'b0;
    for (int i = 0; i < 1700; i++) begin
      @(negedge clk);
      if (i == 0)
        check("first_edge", 32'({d_x, d_y, d_von, d_ls, d_fs}), 32'({10'd0, 10'd0, 3'b111}));
      if (i < DH_TOT && !d_hs) begin
        hs_low++;
        if (int'(d_x) < hs_min_x) hs_min_x = int'(d_x);
        if (int'(d_x) > hs_max_x) hs_max_x = int'(d_x);
      end
      if (i < DH_TOT && d_x == 10'd640) check("def_von_fall", 32'(d_von), 32'(0));
      if (d_ls) begin
        if (last_ls >= 0) check("def_line_period", 32'(i - last_ls), 32'(DH_TOT));
        last_ls = i;
      end
      if (i < SH_TOT * SV_TOT) begin
        if (!l_vs) vs_low_lo++;
        if (h_vs) vs_high_hi++;
      end
      if (i < SH_TOT && h_hs) hs_high_hi++;
      if (l_y >= 10'(SV_VIS) && l_von) von_bad++;
      if (l_fs) begin
        if (last_fs >= 0) check("small_frame_period", 32'(i - last_fs), 32'(SH_TOT * SV_TOT));
        last_fs = i;
      end
      if (prev_x == SH_TOT - 1 && prev_y == SV_TOT - 1 && wraps_seen < 3) begin
        check("frame_wrap", 32'({l_x, l_y, l_fs}), 32'({10'd0, 10'd0, 1'b1}));
        wraps_seen++;
      end
      prev_x = int'(l_x);
      prev_y = int'(l_y);
    end

    check("def_hs_low_cycles", 32'(hs_low), 32'(96));
    check("def_hs_first_x", 32'(hs_min_x), 32'(656));
    check("def_hs_last_x", 32'(hs_max_x), 32'(751));
    check("lo_vs_low_cycles", 32'(vs_low_lo), 32'(SV_SY * SH_TOT));
    check("hi_vs_high_cycles", 32'(vs_high_hi), 32'(SV_SY * SH_TOT));
    check("hi_hs_high_cycles", 32'(hs_high_hi), 32'(SH_SY));
    check("lo_von_outside", 32'(von_bad), 32'(0));
    check("frame_wraps_seen", 32'(wraps_seen), 32'(3));

    // Mid-frame reset: wait (bounded) for a visible pixel, then reset between edges.
    found = 1'b0;
    for (int i = 0; i < 4 * SH_TOT * SV_TOT && !found; i++) begin
      @(negedge clk);
      if (l_x == 10'd5 && l_y == 10'd3) found = 1'b1;
    end
    check("midframe_found", 32'(found), 32'(1));
    #1 rst = 1'b1;
    #1;
    check("async_rst_lo", 32'({l_x, l_y, l_hs, l_vs, l_von, l_ls, l_fs}), 32'({10'd0, 10'd0, 5'b11000}));
    check("async_rst_hi", 32'({h_hs, h_vs, h_von}), 32'(3'b000));
    check("async_rst_def", 32'({d_x, d_y, d_hs, d_vs, d_von}), 32'({10'd0, 10'd0, 3'b110}));
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("restart_lo", 32'({l_x, l_y, l_von, l_ls, l_fs}), 32'({10'd0, 10'd0, 3'b111}));
    repeat (300) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing.md
# vga_timing

Generates 640x480@60 Hz VGA raster timing from the 25 MHz pixel clock produced by the frequency divider. Outputs horizontal/vertical sync, a visible-area flag, and the current pixel coordinates. The renderer and the colour output stage consume these outputs. It is the first stage on the pixel-clock side of the design.

## Interface
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_ACTIVE_LOW, 1, 1 = sync pulses drive 0 when active
- clk  input  1  pixel clock, the 25 MHz divider output; all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- hs  output  1  horizontal sync
- vs  output  1  vertical sync
- video_on  output  1  high while the pixel is inside the visible area
- x  output  10  horizontal position, 0..H_TOTAL-1
- y  output  10  vertical position, 0..V_TOTAL-1
- line_start  output  1  one-cycle pulse when x==0
- frame_start  output  1  one-cycle pulse when x==0 and y==0

## Operation
- H_TOTAL = sum of the four H parameters (default 800).
- V_TOTAL = sum of the four V parameters (default 525).
- Both totals must be ≤1024; checked at elaboration, fatal otherwise.
- Horizontal counter h:
  - runs 0..H_TOTAL-1 and wraps to 0;
  - vertical counter v increments only on that wrap.
- Vertical counter v wraps to 0 when it is at V_TOTAL-1 and h wraps. Both counters wrap on the same edge.
- Decode, per (h,v):
  - video_on = h<H_VISIBLE && v<V_VISIBLE;
  - hs active for h in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC), default [656,752);
  - vs active for v in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC), default [490,492);
  - vs is a function of v only and spans whole lines.
- Active level of hs/vs is 0 if SYNC_ACTIVE_LOW, otherwise 1.
- x/y are the raw counter values, not clamped. Consumers qualify them with video_on.
- There are no other states. The block free-runs; there is no enable and no handshake.

## Timing
- All outputs are registered.
- Outputs in cycle n+1 reflect the counter state (h,v) of cycle n. Fixed latency: 1 cycle.
- While rst is high:
  - h=v=0, x=0, y=0;
  - hs and vs at their inactive level;
  - video_on=0, line_start=0, frame_start=0.
- First rising edge after rst falls:
  - outputs decode (0,0): video_on=1, line_start=1, frame_start=1;
  - counters advance to (1,0).
- Steady state:
  - line_start period is exactly H_TOTAL cycles (800);
  - frame_start period is exactly H_TOTAL*V_TOTAL cycles (420000).
- Reset asserted mid-frame: outputs go to their reset values immediately, without waiting for a clock. The sequence restarts from (0,0) as above. No partial sync pulse is extended.
- Wrap edge (h=H_TOTAL-1, v=V_TOTAL-1): the next decoded state is (0,0). Never (0,V_TOTAL) or (H_TOTAL,·).

## Structure
- Shared package vga_pkg holds:
  - the default 640x480@60 timing constants;
  - the coordinate width constant (10).
  The game renderer reuses the same constants for object placement.
- One sub-module, vga_axis, is a parameterised counter with wrap output plus sync-window and visible decode. It is instantiated twice: horizontal (always enabled) and vertical (enabled by the horizontal wrap). vga_timing adds the output registers and the start pulses.

## Test plan
- Reset, then release: during reset hs=vs=1, video_on=0, x=y=0. First edge after release: frame_start=1, line_start=1, video_on=1, x=0, y=0.
- Horizontal line: video_on falls at x=640. hs is low for exactly 96 cycles, x=656..751. line_start recurs at 800-cycle spacing.
- Vertical frame: vs is low for exactly 2×800=1600 cycles while y=490..491. video_on=0 for all y≥480.
- Frame wrap: after x=799,y=524 the next output is x=0,y=0 with frame_start=1. frame_start spacing is 420000 cycles over 3 frames.
- Reset mid-frame at x=300,y=200: outputs go to reset values asynchronously, before the next clock edge. After release the raster restarts at (0,0) with frame_start=1.
- SYNC_ACTIVE_LOW=0 instance: hs and vs polarities invert. Pulse positions and widths are identical to the default instance.
